// File: rtl/lock_pkg.sv
// Shared types and width helpers for the parametrised passcode lock.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SET_ENTRY,
    ARMED,
    LOCKOUT,
    UNLOCKED
  } lock_state_t;

  // Bits needed to count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Down-counter width for a lockout of `cycles` clocks, never below 1 bit.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Load/decrement down-counter for the lockout period; done is high while it reads zero.
module lockout_timer
  import lock_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  input  logic clr,
  output logic done
);

  localparam int TMR_W = timer_width(LOCKOUT_CYCLES);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = TMR_W'(LOCKOUT_CYCLES - 1);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lock_ctrl_param.sv
// Parametrised passcode lock: programs a DIGITS x DIGIT_W code, verifies entries, locks out
// after MAX_TRIES failures. Define LOCK_MASTER_CODE_EN to enable the MASTER_CODE override.
module lock_ctrl_param
  import lock_pkg::*;
#(
  parameter int                           DIGITS         = 4,
  parameter int                           DIGIT_W        = 4,
  parameter int                           MAX_TRIES      = 3,
  parameter int                           LOCKOUT_CYCLES = 1000000,
  parameter logic [DIGITS*DIGIT_W-1:0]    MASTER_CODE    = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enter,
  input  logic [DIGIT_W-1:0]                  digit,
  input  logic                                set_button,
  input  logic                                lock_button,
  input  logic                                clear,
  output logic                                is_set,
  output logic                                unlocked,
  output logic                                locked_out,
  output logic                                bad_attempt,
  output logic [$clog2(DIGITS+1)-1:0]         digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]      fail_count
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = cnt_width(DIGITS);
  localparam int FAIL_W = cnt_width(MAX_TRIES);

  lock_state_t       state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] entry_q, entry_d;
  logic [CNT_W-1:0]  digit_count_q, digit_count_d;
  logic [FAIL_W-1:0] fail_count_q, fail_count_d;
  logic              is_set_q, is_set_d;
  logic              unlocked_q, unlocked_d;
  logic              bad_attempt_q, bad_attempt_d;

  logic [CODE_W-1:0] captured;
  logic [FAIL_W-1:0] fail_inc;
  logic              complete, master_hit;
  logic              tmr_load, tmr_clr, tmr_done;

  // On the completing enter, captured is the full code with the new digit on top.
  always_comb begin
    captured = entry_q;
    captured[int'(digit_count_q)*DIGIT_W +: DIGIT_W] = digit;
  end

  assign complete = enter && (digit_count_q == CNT_W'(DIGITS - 1));
  assign fail_inc = fail_count_q + FAIL_W'(1);

`ifdef LOCK_MASTER_CODE_EN
  assign master_hit = complete && (captured == MASTER_CODE);
`else
  logic unused_master;
  assign unused_master = ^MASTER_CODE;
  assign master_hit    = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets its hold/default value first so no branch can infer a latch.
    state_d       = state_q;
    code_d        = code_q;
    entry_d       = entry_q;
    digit_count_d = digit_count_q;
    fail_count_d  = fail_count_q;
    is_set_d      = is_set_q;
    unlocked_d    = unlocked_q;
    bad_attempt_d = 1'b0;
    tmr_load      = 1'b0;
    tmr_clr       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!clear && set_button) state_d = SET_ENTRY;
      end

      SET_ENTRY: begin
        if (clear) begin
          entry_d       = '0;
          digit_count_d = '0;
          state_d       = is_set_q ? UNLOCKED : IDLE;
        end else if (set_button) begin
          entry_d       = '0;
          digit_count_d = '0;
        end else if (complete) begin
          code_d        = captured;
          is_set_d      = 1'b1;
          unlocked_d    = 1'b0;
          fail_count_d  = '0;
          entry_d       = '0;
          digit_count_d = '0;
          state_d       = ARMED;
        end else if (enter) begin
          entry_d       = captured;
          digit_count_d = digit_count_q + CNT_W'(1);
        end
      end

      ARMED: begin
        if (clear) begin
          entry_d       = '0;
          digit_count_d = '0;
        end else if (complete) begin
          entry_d       = '0;
          digit_count_d = '0;
          if (master_hit || (captured == code_q)) begin
            unlocked_d   = 1'b1;
            fail_count_d = '0;
            state_d      = UNLOCKED;
          end else begin
            bad_attempt_d = 1'b1;
            fail_count_d  = fail_inc;
            if (fail_inc == FAIL_W'(MAX_TRIES)) begin
              tmr_load = 1'b1;
              state_d  = LOCKOUT;
            end
          end
        end else if (enter) begin
          entry_d       = captured;
          digit_count_d = digit_count_q + CNT_W'(1);
        end
      end

      LOCKOUT: begin
        if (master_hit) begin
          unlocked_d    = 1'b1;
          fail_count_d  = '0;
          tmr_clr       = 1'b1;
          entry_d       = '0;
          digit_count_d = '0;
          state_d       = UNLOCKED;
        end else begin
          if (tmr_done) begin
            fail_count_d = '0;
            state_d      = ARMED;
          end
`ifdef LOCK_MASTER_CODE_EN
          // Non-master entries are collected but silently dropped while locked out.
          if (complete) begin
            entry_d       = '0;
            digit_count_d = '0;
          end else if (enter) begin
            entry_d       = captured;
            digit_count_d = digit_count_q + CNT_W'(1);
          end
`endif
        end
      end

      UNLOCKED: begin
        if (!clear && set_button) begin
          entry_d       = '0;
          digit_count_d = '0;
          state_d       = SET_ENTRY;
        end else if (!clear && lock_button) begin
          unlocked_d = 1'b0;
          state_d    = ARMED;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .dec  (state_q == LOCKOUT),
    .clr  (tmr_clr),
    .done (tmr_done)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      // NOTE: the code register is reset as well; a reset must forget the programmed code.
      code_q        <= '0;
      entry_q       <= '0;
      digit_count_q <= '0;
      fail_count_q  <= '0;
      is_set_q      <= 1'b0;
      unlocked_q    <= 1'b0;
      bad_attempt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      entry_q       <= entry_d;
      digit_count_q <= digit_count_d;
      fail_count_q  <= fail_count_d;
      is_set_q      <= is_set_d;
      unlocked_q    <= unlocked_d;
      bad_attempt_q <= bad_attempt_d;
    end
  end

  assign is_set      = is_set_q;
  assign unlocked    = unlocked_q;
  assign locked_out  = (state_q == LOCKOUT);
  assign bad_attempt = bad_attempt_q;
  assign digit_count = digit_count_q;
  assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_lock_ctrl_param.sv
// Directed, table-driven bench for lock_ctrl_param (4 digits x 4 bits, 3 tries, 8-cycle lockout).
`timescale 1ns/1ps
module tb_lock_ctrl_param;

`ifdef LOCK_MASTER_CODE_EN
  localparam bit M = 1'b1;
`else
  localparam bit M = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enter, set_button, lock_button, clear;
  logic [3:0] digit;
  logic       is_set, unlocked, locked_out, bad_attempt;
  logic [2:0] digit_count;
  logic [1:0] fail_count;

  int n_checks = 0;
  int n_errors = 0;

  // Expected/observed bundle: {is_set, unlocked, locked_out, bad_attempt, digit_count, fail_count}
  typedef struct {
    logic       enter;
    logic [3:0] digit;
    logic       set_b;
    logic       lock_b;
    logic       clr;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  lock_ctrl_param #(
    .DIGITS        (4),
    .DIGIT_W       (4),
    .MAX_TRIES     (3),
    .LOCKOUT_CYCLES(8),
    .MASTER_CODE   (16'hBEEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enter      (enter),
    .digit      (digit),
    .set_button (set_button),
    .lock_button(lock_button),
    .clear      (clear),
    .is_set     (is_set),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .bad_attempt(bad_attempt),
    .digit_count(digit_count),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [8:0] ex(input bit is, input bit un, input bit lo, input bit bd,
                                    input int dc, input int fc);
    return {is, un, lo, bd, 3'(dc), 2'(fc)};
  endfunction

  function automatic logic [8:0] observed();
    return {is_set, unlocked, locked_out, bad_attempt, digit_count, fail_count};
  endfunction

  task automatic add(input bit e, input int d, input bit s, input bit l, input bit c,
                     input logic [8:0] exp);
    vec_t v;
    v.enter = e; v.digit = 4'(d); v.set_b = s; v.lock_b = l; v.clr = c; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {is,un,lo,bad,dc,fc}=%b_%b_%b_%b_%0d_%0d required %b_%b_%b_%b_%0d_%0d",
               name, act[8], act[7], act[6], act[5], act[4:2], act[1:0],
               exp[8], exp[7], exp[6], exp[5], exp[4:2], exp[1:0]);
    end
  endtask

  // Drive one cycle of pulses, sample #1 after the edge, then release all pulses.
  task automatic cycle(input bit e, input int d, input bit s, input bit l, input bit c);
    enter = e; digit = 4'(d); set_button = s; lock_button = l; clear = c;
    @(posedge clk);
    #1;
    enter = 1'b0; digit = 4'h0; set_button = 1'b0; lock_button = 1'b0; clear = 1'b0;
  endtask

  task automatic bad_entries();
    for (int t = 1; t <= 3; t++)
      for (int i = 1; i <= 4; i++)
        add(1, 0, 0, 0, 0, ex(1, 0, (t == 3) && (i == 4), i == 4, i % 4, (i == 4) ? t : t - 1));
  endtask

  initial begin
    logic [3:0] md [4];
    md[0] = 4'hF; md[1] = 4'hE; md[2] = 4'hE; md[3] = 4'hB;

    rst = 1'b0;
    enter = 1'b0; digit = 4'h0; set_button = 1'b0; lock_button = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", observed(), ex(0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_released", observed(), ex(0, 0, 0, 0, 0, 0));

    // Program 1,2,3,4
    add(0, 0, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++) add(1, i, 0, 0, 0, ex(i == 4, 0, 0, 0, i % 4, 0));
    // Verify, then relock
    for (int i = 1; i <= 4; i++) add(1, i, 0, 0, 0, ex(1, i == 4, 0, 0, i % 4, 0));
    add(0, 0, 0, 1, 0, ex(1, 0, 0, 0, 0, 0));
    // Three wrong entries -> lockout; 7 more locked cycles (first 4 with enter), release on 8th
    bad_entries();
    for (int k = 1; k <= 7; k++)
      add(k <= 4, 0, 0, 0, 0, ex(1, 0, 1, 0, (M && k <= 3) ? k : 0, 3));
    add(0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0));
    // Clear wins over a simultaneous enter, then correct code
    add(1, 1, 0, 0, 0, ex(1, 0, 0, 0, 1, 0));
    add(1, 2, 0, 0, 0, ex(1, 0, 0, 0, 2, 0));
    add(1, 3, 0, 0, 1, ex(1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++) add(1, i, 0, 0, 0, ex(1, i == 4, 0, 0, i % 4, 0));
    add(0, 0, 0, 1, 0, ex(1, 0, 0, 0, 0, 0));
    // Lock out again, then try the master code F,E,E,B (LSB digit first)
    bad_entries();
    for (int i = 0; i < 4; i++)
      add(1, int'(md[i]), 0, 0, 0,
          M ? ex(1, i == 3, i != 3, 0, (i + 1) % 4, (i == 3) ? 0 : 3)
            : ex(1, 0, 1, 0, 0, 3));

    foreach (vecs[i]) begin
      cycle(vecs[i].enter, int'(vecs[i].digit), vecs[i].set_b, vecs[i].lock_b, vecs[i].clr);
      check($sformatf("vec%0d", i), observed(), vecs[i].exp);
    end

    // Async reset mid-entry, asserted between clock edges
    rst = 1'b0;
    #2;
    rst = 1'b1;
    cycle(0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 2, 0, 0, 0);
    check("mid_entry_before_reset", observed(), ex(1, 0, 0, 0, 2, 0));
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_between_edges", observed(), ex(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle(1, i, 0, 0, 0);
      check($sformatf("idle_enter%0d", i), observed(), ex(0, 0, 0, 0, 0, 0));
    end

    // Clear in SET_ENTRY with no stored code drops back to IDLE
    cycle(0, 0, 1, 0, 0);
    cycle(1, 5, 0, 0, 0);
    check("set_entry_partial", observed(), ex(0, 0, 0, 0, 1, 0));
    cycle(0, 0, 0, 0, 1);
    check("set_entry_clear", observed(), ex(0, 0, 0, 0, 0, 0));
    cycle(1, 6, 0, 0, 0);
    check("idle_after_clear", observed(), ex(0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
